// File: rtl/dmem_ctrl.sv
// Byte-addressed RV32I data memory controller: valid/ready requests, fixed-latency registered responses.
// Optional DMEM_ERR_CNT_EN adds a saturating err_count output counting faulted responses.
module dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              cap_we;
  logic [2:0]        cap_f3;
  logic [ADDR_W-1:0] cap_addr;
  logic              accept;

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both high;
  // req_ready is high only while idle and out of reset, so at most one transaction is in flight.
  assign req_ready = (state_q == S_IDLE) && rst_n;
  assign accept    = req_valid && req_ready;

  // While idle the live request is the one being decoded; afterwards the captured copy is.
  logic              eff_we;
  logic [2:0]        eff_f3;
  logic [ADDR_W-1:0] eff_addr;
  logic [IDX_W-1:0]  eff_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic [1:0]        off;

  assign eff_we   = (state_q == S_IDLE) ? req_we     : cap_we;
  assign eff_f3   = (state_q == S_IDLE) ? req_funct3 : cap_f3;
  assign eff_addr = (state_q == S_IDLE) ? req_addr   : cap_addr;
  assign eff_idx  = eff_addr[ADDR_W-1:2];
  assign mem_idx  = eff_idx[MEM_AW-1:0];
  assign off      = eff_addr[1:0];

  logic is_half, is_word, fn_err, eff_err;

  always_comb begin
    is_half = (eff_f3[1:0] == 2'b01);
    is_word = (eff_f3 == 3'b010);
    if (eff_we) fn_err = !(eff_f3 == 3'b000 || eff_f3 == 3'b001 || eff_f3 == 3'b010);
    else        fn_err = (eff_f3 == 3'b011 || eff_f3 == 3'b110 || eff_f3 == 3'b111);
    eff_err = fn_err
            || (32'(eff_idx) >= DEPTH)
            || (is_half && off[0])
            || (is_word && (off != 2'b00));
  end

  // Store lane enables and lane-replicated write data.
  logic [3:0]  be;
  logic [31:0] wr_lanes;

  always_comb begin
    be       = 4'b0000;
    wr_lanes = req_wdata;
    case (req_funct3[1:0])
      2'b00:   begin be = 4'b0001 << off; wr_lanes = {4{req_wdata[7:0]}};  end
      2'b01:   begin be = off[1] ? 4'b1100 : 4'b0011; wr_lanes = {2{req_wdata[15:0]}}; end
      default: be = 4'b1111;
    endcase
  end

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (accept && req_we && !eff_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  logic [31:0] rd_word, load_data;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_word   = mem[mem_idx];
    rd_byte   = rd_word[8*off +: 8];
    rd_half   = off[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    if (!eff_err && !eff_we) begin
      case (eff_f3)
        3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
        3'b100:  load_data = {24'h0, rd_byte};
        3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
        3'b101:  load_data = {16'h0, rd_half};
        3'b010:  load_data = rd_word;
        default: load_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          wait_cnt_d = 4'd0;
          state_d    = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == 4'(WAIT_STATES - 1)) state_d = S_RESP;
        else                                   wait_cnt_d = wait_cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      cap_we     <= 1'b0;
      cap_f3     <= 3'b000;
      cap_addr   <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (accept) begin
        cap_we   <= req_we;
        cap_f3   <= req_funct3;
        cap_addr <= req_addr;
      end
      rsp_valid <= (state_d == S_RESP);
      if (state_d == S_RESP) begin
        rsp_err   <= eff_err;
        rsp_rdata <= load_data;
      end
    end
  end

`ifdef DMEM_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        err_count <= 16'h0;
    else if (rsp_valid && rsp_err && err_count != 16'hFFFF) err_count <= err_count + 16'h1;
  end
`endif

endmodule
